// File: rtl/forwarding_control_unit.sv
// Forwarding and load-use hazard control for the 5-stage LEGv8 pipeline.
// Keeps shadow copies of the EX/MEM and MEM/WB destination/control bits.
//
// Ports:
//   CLOCK, RESET          rising-edge clock, synchronous active-high reset
//   IDEX_Rn/Rm/Rd         source/destination registers of the EX instruction
//   IDEX_RegWrite/MemRead control bits of the EX instruction
//   IFID_Rn/Rm            source registers of the ID instruction
//   EXMEM_Flush           turn the instruction leaving EX into a bubble
//   pipelineHold          freeze all state (memory wait)
//   ForwardA/ForwardB     operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   loadUseStall          stall IF/ID and bubble ID/EX this cycle
//   stallCount            saturating count of load-use stall cycles
module forwarding_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 31,
    parameter int CNT_W      = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [REG_ADDR_W-1:0] IDEX_Rn,
    input  logic [REG_ADDR_W-1:0] IDEX_Rm,
    input  logic [REG_ADDR_W-1:0] IDEX_Rd,
    input  logic                  IDEX_RegWrite,
    input  logic                  IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0] IFID_Rn,
    input  logic [REG_ADDR_W-1:0] IFID_Rm,
    input  logic                  EXMEM_Flush,
    input  logic                  pipelineHold,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  loadUseStall,
    output logic [CNT_W-1:0]      stallCount
);

    localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  exmem_reg_write;
    logic                  exmem_mem_read;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic                  memwb_reg_write;
    logic [CNT_W-1:0]      stall_cnt;

    // A load in EX/MEM has no result yet, so it never forwards from there.
    logic exmem_src;
    logic memwb_src;

    assign exmem_src = exmem_reg_write && !exmem_mem_read && (exmem_rd != ZR);
    assign memwb_src = memwb_reg_write && (memwb_rd != ZR);

    always_comb begin
        ForwardA = 2'b00;
        if (exmem_src && (exmem_rd == IDEX_Rn)) begin
            ForwardA = 2'b10;
        end else if (memwb_src && (memwb_rd == IDEX_Rn)) begin
            ForwardA = 2'b01;
        end
    end

    always_comb begin
        ForwardB = 2'b00;
        if (exmem_src && (exmem_rd == IDEX_Rm)) begin
            ForwardB = 2'b10;
        end else if (memwb_src && (memwb_rd == IDEX_Rm)) begin
            ForwardB = 2'b01;
        end
    end

    // A flushed load is being killed, so it cannot cause a stall.
    always_comb begin
        loadUseStall = 1'b0;
        if (IDEX_MemRead && !EXMEM_Flush && (IDEX_Rd != ZR)) begin
            loadUseStall = (IDEX_Rd == IFID_Rn) || (IDEX_Rd == IFID_Rm);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            exmem_rd        <= '0;
            exmem_reg_write <= 1'b0;
            exmem_mem_read  <= 1'b0;
            memwb_rd        <= '0;
            memwb_reg_write <= 1'b0;
            stall_cnt       <= '0;
        end else if (!pipelineHold) begin
            memwb_rd        <= exmem_rd;
            memwb_reg_write <= exmem_reg_write;
            if (EXMEM_Flush) begin
                exmem_rd        <= '0;
                exmem_reg_write <= 1'b0;
                exmem_mem_read  <= 1'b0;
            end else begin
                exmem_rd        <= IDEX_Rd;
                exmem_reg_write <= IDEX_RegWrite;
                exmem_mem_read  <= IDEX_MemRead;
            end
            if (loadUseStall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign stallCount = stall_cnt;

endmodule

// File: tb/tb_forwarding_control_unit.sv
// Directed table-driven bench for forwarding_control_unit.
// Second instance with CNT_W=4 exercises counter saturation.
module tb_forwarding_control_unit;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [4:0]  IDEX_Rn, IDEX_Rm, IDEX_Rd;
    logic        IDEX_RegWrite, IDEX_MemRead;
    logic [4:0]  IFID_Rn, IFID_Rm;
    logic        EXMEM_Flush, pipelineHold;
    logic [1:0]  ForwardA, ForwardB, ForwardA4, ForwardB4;
    logic        loadUseStall, loadUseStall4;
    logic [15:0] stallCount;
    logic [3:0]  stallCount4;

    int tests = 0;
    int fails = 0;

    always #5 CLOCK = ~CLOCK;

    forwarding_control_unit dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IDEX_Rn(IDEX_Rn), .IDEX_Rm(IDEX_Rm), .IDEX_Rd(IDEX_Rd),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm),
        .EXMEM_Flush(EXMEM_Flush), .pipelineHold(pipelineHold),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .loadUseStall(loadUseStall), .stallCount(stallCount)
    );

    forwarding_control_unit #(.CNT_W(4)) dut4 (
        .CLOCK(CLOCK), .RESET(RESET),
        .IDEX_Rn(IDEX_Rn), .IDEX_Rm(IDEX_Rm), .IDEX_Rd(IDEX_Rd),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm),
        .EXMEM_Flush(EXMEM_Flush), .pipelineHold(pipelineHold),
        .ForwardA(ForwardA4), .ForwardB(ForwardB4),
        .loadUseStall(loadUseStall4), .stallCount(stallCount4)
    );

    typedef struct {
        logic [4:0]  rn, rm, rd;
        logic        rw, mr;
        logic [4:0]  frn, frm;
        logic        fl, hd;
        logic [1:0]  fa, fb;
        logic        st;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input int rn, input int rm, input int rd,
        input int rw, input int mr,
        input int frn, input int frm,
        input int fl, input int hd,
        input int fa, input int fb, input int st, input int cnt
    );
        vec_t v;
        v.rn = 5'(rn); v.rm = 5'(rm); v.rd = 5'(rd);
        v.rw = 1'(rw); v.mr = 1'(mr);
        v.frn = 5'(frn); v.frm = 5'(frm);
        v.fl = 1'(fl); v.hd = 1'(hd);
        v.fa = 2'(fa); v.fb = 2'(fb); v.st = 1'(st);
        v.cnt = 16'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %0d, expected %0d",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        IDEX_Rn = v.rn; IDEX_Rm = v.rm; IDEX_Rd = v.rd;
        IDEX_RegWrite = v.rw; IDEX_MemRead = v.mr;
        IFID_Rn = v.frn; IFID_Rm = v.frm;
        EXMEM_Flush = v.fl; pipelineHold = v.hd;
    endtask

    initial begin
        int m16;
        int m4;

        // rn rm rd rw mr frn frm fl hd | fa fb st cnt
        // reset state
        vecs.push_back(mk( 3, 3, 0,1'b0,0, 0,0, 0,0, 0,0,0,0));
        // back-to-back dependency on X5
        vecs.push_back(mk( 1, 2, 5,1,0, 0,0, 0,0, 0,0,0,0));
        vecs.push_back(mk( 5, 5, 0,0,0, 0,0, 0,0, 2,2,0,0));
        vecs.push_back(mk( 5, 5, 0,0,0, 0,0, 0,0, 1,1,0,0));
        vecs.push_back(mk( 5, 5, 0,0,0, 0,0, 0,0, 0,0,0,0));
        // double hazard on X7
        vecs.push_back(mk( 0, 0, 7,1,0, 0,0, 0,0, 0,0,0,0));
        vecs.push_back(mk( 1, 2, 7,1,0, 0,0, 0,0, 0,0,0,0));
        vecs.push_back(mk( 7, 8, 0,0,0, 0,0, 0,0, 2,0,0,0));
        vecs.push_back(mk( 8, 7, 0,0,0, 0,0, 0,0, 0,1,0,0));
        // same with XZR: never forwarded
        vecs.push_back(mk( 0, 0,31,1,0, 0,0, 0,0, 0,0,0,0));
        vecs.push_back(mk( 1, 1,31,1,0, 0,0, 0,0, 0,0,0,0));
        vecs.push_back(mk(31,31, 0,0,0, 0,0, 0,0, 0,0,0,0));
        vecs.push_back(mk(31,31, 0,0,0, 0,0, 0,0, 0,0,0,0));
        // load-use on X9, then flushed stall, load not forwarded
        vecs.push_back(mk( 1, 2, 9,1,1, 0,9, 0,0, 0,0,1,0));
        vecs.push_back(mk( 9, 2, 9,1,1, 0,9, 1,0, 0,0,0,1));
        vecs.push_back(mk( 9, 0, 0,0,0, 0,0, 0,0, 1,0,0,1));
        // hold with X2 in EX/MEM and X4 writer in EX
        vecs.push_back(mk( 0, 0, 2,1,0, 0,0, 0,0, 0,0,0,1));
        vecs.push_back(mk( 2, 4, 4,1,0, 0,0, 0,1, 2,0,0,1));
        vecs.push_back(mk( 2, 4, 4,1,0, 0,0, 0,1, 2,0,0,1));
        vecs.push_back(mk( 2, 4, 4,1,1, 4,0, 0,1, 2,0,1,1));
        // release with flush: X4 becomes a bubble
        vecs.push_back(mk( 2, 4, 4,1,1, 4,0, 1,0, 2,0,0,1));
        vecs.push_back(mk( 4, 2, 0,0,0, 0,0, 0,0, 0,1,0,1));

        RESET = 1'b1;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            @(negedge CLOCK);
            drive(vecs[i]);
            #1;
            chk("ForwardA", i, int'(ForwardA), int'(vecs[i].fa));
            chk("ForwardB", i, int'(ForwardB), int'(vecs[i].fb));
            chk("loadUseStall", i, int'(loadUseStall), int'(vecs[i].st));
            chk("stallCount", i, int'(stallCount), int'(vecs[i].cnt));
        end

        // continuous load-use stall: 4-bit counter saturates at 15
        m16 = 1;
        m4  = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            drive(mk(0,0,9,1,1,0,9,0,0,0,0,0,0));
            #1;
            chk("sat_stall", i, int'(loadUseStall4), 1);
            chk("sat_cnt4", i, int'(stallCount4), m4);
            chk("sat_cnt16", i, int'(stallCount), m16);
            m16 = m16 + 1;
            if (m4 < 15) m4 = m4 + 1;
        end
        @(negedge CLOCK);
        #1;
        chk("sat_final4", 0, int'(stallCount4), 15);
        chk("sat_final16", 0, int'(stallCount), 21);

        // reset mid-sequence drops X9 writer and counter
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        drive(mk(9,9,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        chk("rst_fa", 0, int'(ForwardA), 0);
        chk("rst_fb", 0, int'(ForwardB), 0);
        chk("rst_fa4", 0, int'(ForwardA4), 0);
        chk("rst_stall", 0, int'(loadUseStall), 0);
        chk("rst_cnt", 0, int'(stallCount), 0);
        chk("rst_cnt4", 0, int'(stallCount4), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
